led_bank_sequencer: RTL and testbench

Controller that sequences commits of the 3-bit switch value into a bank of LED registers. It debounces a commit button and a clear button. Each commit press writes `sel` into the bank slot at a round-robin pointer, and a clear press sweeps all slots to zero. It sits between the board switches/buttons and the LED outputs.

---
 rtl/led_seq_pkg.sv | 19 +
 rtl/btn_filter.sv | 39 +++
 rtl/led_bank_sequencer.sv | 143 ++++++++++++++
 tb/tb_led_bank_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and default constants for the LED bank sequencer.
//   state_t          : sequencer FSM states
//   DEF_DATA_W       : default slot / switch width
//   DEF_NUM_BANKS    : default number of LED slots
//   DEF_DEB_CYCLES   : default debounce length in clk cycles
package led_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        CLEAR    = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    localparam int DEF_DATA_W     = 3;
    localparam int DEF_NUM_BANKS  = 4;
    localparam int DEF_DEB_CYCLES = 250000;

endpackage

// File: rtl/btn_filter.sv
// Button debouncer: the output follows the input only after the input has
// disagreed with it for DEB_CYCLES consecutive samples.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (output and counter to 0)
//   din  : input, already synchronous to clk
//   dout : debounced level
module btn_filter #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int                CNT_W   = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din != dout) begin
            if (cnt == CNT_MAX) begin
                dout <= ~dout;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/led_bank_sequencer.sv
// Commits the switch value into a round-robin bank of LED slots on a
// debounced commit press; a debounced clear press sweeps all slots to zero.
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   sel          : value to commit (sampled only in the WRITE cycle)
//   commit_btn   : raw commit button
//   clear_btn    : raw clear button
//   leds         : slot k at bits [k*DATA_W +: DATA_W]
//   bank_ptr     : next slot to be written
//   commit_pulse : high during the WRITE cycle
//   busy         : high whenever the FSM is not IDLE
// Build option: define LED_BANK_SYNC_EN to add a 2-flop synchronizer in
// front of each debouncer (for truly asynchronous buttons, +2 cycles).
module led_bank_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_BANKS  = DEF_NUM_BANKS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             sel,
    input  logic                          commit_btn,
    input  logic                          clear_btn,
    output logic [NUM_BANKS*DATA_W-1:0]   leds,
    output logic [$clog2(NUM_BANKS)-1:0]  bank_ptr,
    output logic                          commit_pulse,
    output logic                          busy
);

    localparam int               PTR_W    = $clog2(NUM_BANKS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_BANKS - 1);

    logic   commit_raw, clear_raw;
    logic   commit_f, clear_f;
    logic   commit_q, clear_q;
    logic   commit_rise, clear_rise;
    state_t state, state_next;
    logic [PTR_W-1:0] sweep_idx;

`ifdef LED_BANK_SYNC_EN
    logic [1:0] commit_sync, clear_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_sync <= '0;
            clear_sync  <= '0;
        end else begin
            commit_sync <= {commit_sync[0], commit_btn};
            clear_sync  <= {clear_sync[0], clear_btn};
        end
    end

    assign commit_raw = commit_sync[1];
    assign clear_raw  = clear_sync[1];
`else
    assign commit_raw = commit_btn;
    assign clear_raw  = clear_btn;
`endif

    btn_filter #(.DEB_CYCLES(DEB_CYCLES)) u_commit_filter (
        .clk  (clk),
        .rst  (rst),
        .din  (commit_raw),
        .dout (commit_f)
    );

    btn_filter #(.DEB_CYCLES(DEB_CYCLES)) u_clear_filter (
        .clk  (clk),
        .rst  (rst),
        .din  (clear_raw),
        .dout (clear_f)
    );

    // Edge registers track the filtered levels in every state, so an edge
    // seen outside IDLE is consumed and never replayed later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_q <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            commit_q <= commit_f;
            clear_q  <= clear_f;
        end
    end

    assign commit_rise = commit_f & ~commit_q;
    assign clear_rise  = clear_f  & ~clear_q;

    // NOTE: default assigned first so no path leaves state_next unassigned
    // (which would infer a latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (clear_rise)       state_next = CLEAR;
                else if (commit_rise) state_next = WRITE;
            end
            WRITE:    state_next = WAIT_REL;
            CLEAR:    if (sweep_idx == LAST_IDX) state_next = WAIT_REL;
            WAIT_REL: if (!commit_f && !clear_f) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Outputs are registered from state_next, so they line up with the
    // state register and add no delay.
    // NOTE: the LED slots are ordinary flops with async reset, so a reset
    // in mid-WRITE or mid-CLEAR leaves every slot zero at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            leds         <= '0;
            bank_ptr     <= '0;
            sweep_idx    <= '0;
            commit_pulse <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            commit_pulse <= (state_next == WRITE);
            busy         <= (state_next != IDLE);

            if (state == WRITE) begin
                leds[int'(bank_ptr)*DATA_W +: DATA_W] <= sel;
                bank_ptr <= (bank_ptr == LAST_IDX) ? '0 : bank_ptr + 1'b1;
            end

            if (state == CLEAR) begin
                leds[int'(sweep_idx)*DATA_W +: DATA_W] <= '0;
                if (sweep_idx == LAST_IDX) begin
                    sweep_idx <= '0;
                    bank_ptr  <= '0;
                end else begin
                    sweep_idx <= sweep_idx + 1'b1;
                end
            end else begin
                sweep_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_led_bank_sequencer.sv
// Self-checking bench for led_bank_sequencer with NUM_BANKS=4, DATA_W=3,
// DEB_CYCLES=4. Inputs change 1 time unit after a rising edge and outputs
// are checked at that same point, well away from the next edge.
module tb_led_bank_sequencer;

    localparam int NB  = 4;
    localparam int DW  = 3;
    localparam int DEB = 4;
`ifdef LED_BANK_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW-1:0]     sel = '0;
    logic              commit_btn = 1'b0;
    logic              clear_btn  = 1'b0;
    logic [NB*DW-1:0]  leds;
    logic [1:0]        bank_ptr;
    logic              commit_pulse;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    led_bank_sequencer #(
        .NUM_BANKS  (NB),
        .DATA_W     (DW),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sel          (sel),
        .commit_btn   (commit_btn),
        .clear_btn    (clear_btn),
        .leds         (leds),
        .bank_ptr     (bank_ptr),
        .commit_pulse (commit_pulse),
        .busy         (busy)
    );

    typedef struct {
        logic [DW-1:0]    sel;
        logic [NB*DW-1:0] exp_leds;
        logic [1:0]       exp_ptr;
    } commit_vec_t;

    commit_vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_outs(input string tag, input logic [NB*DW-1:0] e_leds,
                              input logic [1:0] e_ptr, input logic e_pulse, input logic e_busy);
        check({tag, ".leds"},  32'(leds),         32'(e_leds));
        check({tag, ".ptr"},   32'(bank_ptr),     32'(e_ptr));
        check({tag, ".pulse"}, 32'(commit_pulse), 32'(e_pulse));
        check({tag, ".busy"},  32'(busy),         32'(e_busy));
    endtask

    // Full press/release of commit; sel is scrambled right after the write
    // to show it is not captured outside WRITE.
    task automatic do_commit(input string tag, input logic [DW-1:0] v,
                             input logic [NB*DW-1:0] e_leds, input logic [1:0] e_ptr);
        sel        = v;
        commit_btn = 1'b1;
        tick(DEB + 1 + S);
        check({tag, ".pulse_in_write"}, 32'(commit_pulse), 32'd1);
        tick(1);
        sel        = ~v;
        commit_btn = 1'b0;
        tick(DEB + 1 + S);
        check_outs(tag, e_leds, e_ptr, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{3'd1, {3'd0, 3'd0, 3'd0, 3'd1}, 2'd1};
        vecs[1] = '{3'd2, {3'd0, 3'd0, 3'd2, 3'd1}, 2'd2};
        vecs[2] = '{3'd3, {3'd0, 3'd3, 3'd2, 3'd1}, 2'd3};
        vecs[3] = '{3'd4, {3'd4, 3'd3, 3'd2, 3'd1}, 2'd0};
        vecs[4] = '{3'd6, {3'd4, 3'd3, 3'd2, 3'd6}, 2'd1};

        // Power-on reset
        tick(2);
        check_outs("por", '0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(2);

        // Single commit: filtered rise at edge DEB+S, WRITE next, update after
        sel        = 3'b101;
        commit_btn = 1'b1;
        tick(DEB + S);
        check_outs("c1_filt", '0, 2'd0, 1'b0, 1'b0);
        tick(1);
        check_outs("c1_write", '0, 2'd0, 1'b1, 1'b1);
        tick(1);
        check_outs("c1_done", 12'd5, 2'd1, 1'b0, 1'b1);
        tick(4);
        commit_btn = 1'b0;
        tick(DEB + S);
        check_outs("c1_relfilt", 12'd5, 2'd1, 1'b0, 1'b1);
        tick(1);
        check_outs("c1_idle", 12'd5, 2'd1, 1'b0, 1'b0);

        // Glitch shorter than the debounce window
        sel        = 3'd7;
        commit_btn = 1'b1;
        tick(DEB - 1);
        commit_btn = 1'b0;
        tick(8);
        check_outs("glitch", 12'd5, 2'd1, 1'b0, 1'b0);

        // Commit then clear + re-press during WAIT_REL: both edges ignored
        sel        = 3'd3;
        commit_btn = 1'b1;
        tick(DEB + 2 + S);
        check_outs("wr_write", {3'd0, 3'd0, 3'd3, 3'd5}, 2'd2, 1'b0, 1'b1);
        clear_btn  = 1'b1;
        commit_btn = 1'b0;
        tick(DEB);
        commit_btn = 1'b1;
        tick(DEB);
        check_outs("wr_ignored", {3'd0, 3'd0, 3'd3, 3'd5}, 2'd2, 1'b0, 1'b1);
        commit_btn = 1'b0;
        clear_btn  = 1'b0;
        tick(DEB + 4 + S);
        check_outs("wr_idle", {3'd0, 3'd0, 3'd3, 3'd5}, 2'd2, 1'b0, 1'b0);

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        check_outs("async_rst", '0, 2'd0, 1'b0, 1'b0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // Five commits, pointer wraps
        for (int i = 0; i < 5; i++)
            do_commit($sformatf("tbl%0d", i), vecs[i].sel, vecs[i].exp_leds, vecs[i].exp_ptr);

        // Simultaneous commit + clear: clear wins, one slot per cycle
        sel        = 3'd7;
        commit_btn = 1'b1;
        clear_btn  = 1'b1;
        tick(DEB + 1 + S);
        check_outs("clr_s0", {3'd4, 3'd3, 3'd2, 3'd6}, 2'd1, 1'b0, 1'b1);
        tick(1);
        check_outs("clr_s1", {3'd4, 3'd3, 3'd2, 3'd0}, 2'd1, 1'b0, 1'b1);
        tick(1);
        check_outs("clr_s2", {3'd4, 3'd3, 3'd0, 3'd0}, 2'd1, 1'b0, 1'b1);
        tick(1);
        check_outs("clr_s3", {3'd4, 3'd0, 3'd0, 3'd0}, 2'd1, 1'b0, 1'b1);
        tick(1);
        check_outs("clr_s4", '0, 2'd0, 1'b0, 1'b1);
        commit_btn = 1'b0;
        clear_btn  = 1'b0;
        tick(DEB + 2 + S);
        check_outs("clr_idle", '0, 2'd0, 1'b0, 1'b0);

        // Reset in the middle of WRITE aborts it
        do_commit("pre_abort", 3'd5, 12'd5, 2'd1);
        sel        = 3'd6;
        commit_btn = 1'b1;
        tick(DEB + 1 + S);
        check("abort.pulse_before", 32'(commit_pulse), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_outs("abort", '0, 2'd0, 1'b0, 1'b0);
        tick(1);
        commit_btn = 1'b0;
        rst        = 1'b0;
        tick(DEB + 4);
        check_outs("abort_after", '0, 2'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
